// File: rtl/puf_serial_engine.sv
// puf_serial_engine: serial ring-oscillator PUF, one RO pair per response bit.
// Pairs are measured one after another over a fixed clk window with shared counters.
module puf_serial_engine #(
    parameter int N_RO      = 32,
    parameter int RESP_BITS = 8,
    parameter int WINDOW    = 1024,
    parameter int CNT_W     = 16,
    parameter int STAGES    = 5,
    parameter int SIM_RO    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_RO-1:0]      enables,
    input  logic [RESP_BITS-1:0] challenge,
    output logic [RESP_BITS-1:0] response,
    output logic                 done
);

    localparam int K_W     = $clog2(RESP_BITS);
    localparam int IDX_W   = K_W + 2;
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WT_W    = 3;
    // real ROs need 4 settle cycles plus the compare cycle
    localparam int CMP_CYC = (SIM_RO != 0) ? 1 : 5;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] COUNT  = 3'd2;
    localparam logic [2:0] CMP    = 3'd3;
    localparam logic [2:0] UPDATE = 3'd4;

    logic [2:0]           state;
    logic [2:0]           nxt_state;
    logic [K_W-1:0]       k;
    logic [WIN_W-1:0]     win;
    logic [WT_W-1:0]      wt;
    logic [RESP_BITS-1:0] chal_q;
    logic [N_RO-1:0]      en_q;
    logic [RESP_BITS-1:0] shadow;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;
    logic [IDX_W-1:0]     ia;
    logic [IDX_W-1:0]     ib;
    logic                 win_last;
    logic                 cmp_last;
    logic                 bit_last;

    assign ia = {k, chal_q[k], 1'b0};
    assign ib = {k, chal_q[k], 1'b1};

    assign win_last = (win == WIN_W'(WINDOW - 1));
    assign cmp_last = (wt == WT_W'(CMP_CYC - 1));
    assign bit_last = (k == K_W'(RESP_BITS - 1));

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] ro_weight(
        input logic [3:0] i
    );
        logic [3:0] m;
        m = i * 4'd7;
        return {{(CNT_W-4){1'b0}}, m} + CNT_W'(1);
    endfunction

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE:    nxt_state = CLEAR;
            CLEAR:   nxt_state = COUNT;
            COUNT:   nxt_state = win_last ? CMP : COUNT;
            CMP: begin
                if (cmp_last)
                    nxt_state = bit_last ? UPDATE : CLEAR;
            end
            UPDATE:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            win      <= '0;
            wt       <= '0;
            chal_q   <= '0;
            en_q     <= '0;
            shadow   <= '0;
            response <= '0;
            done     <= 1'b0;
        end else begin
            state <= nxt_state;
            unique case (state)
                IDLE: begin
                    chal_q <= challenge;
                    en_q   <= enables;
                    k      <= '0;
                end
                CLEAR: begin
                    win <= '0;
                    wt  <= '0;
                end
                COUNT: win <= win + 1'b1;
                CMP: begin
                    wt <= wt + 1'b1;
                    if (cmp_last) begin
                        shadow[k] <= (cnt_a > cnt_b);
                        k         <= k + 1'b1;
                    end
                end
                UPDATE: begin
                    response <= shadow;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    generate
        if (SIM_RO != 0) begin : g_sim
            logic [CNT_W-1:0] wa;
            logic [CNT_W-1:0] wb;

            // each enabled RO contributes a fixed per-index rate
            assign wa = en_q[ia] ? ro_weight(ia[3:0]) : '0;
            assign wb = en_q[ib] ? ro_weight(ib[3:0]) : '0;

            always_ff @(posedge clk) begin
                if (reset || state == CLEAR) begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                end else if (state == COUNT) begin
                    cnt_a <= sat_add(cnt_a, wa);
                    cnt_b <= sat_add(cnt_b, wb);
                end
            end
        end else begin : g_real
            logic [N_RO-1:0]  ro_run;
            logic             ro_clr;
            logic [N_RO-1:0]  pair_mask;
            logic [CNT_W-1:0] ro_cnt [N_RO];
            logic [CNT_W-1:0] a_s1;
            logic [CNT_W-1:0] b_s1;

            always_comb begin
                pair_mask     = '0;
                pair_mask[ia] = 1'b1;
                pair_mask[ib] = 1'b1;
            end

            // run gate is a clk-domain register so the window is exact
            always_ff @(posedge clk) begin
                if (reset) begin
                    ro_run <= '0;
                    ro_clr <= 1'b1;
                    a_s1   <= '0;
                    b_s1   <= '0;
                    cnt_a  <= '0;
                    cnt_b  <= '0;
                end else begin
                    ro_clr <= (nxt_state == CLEAR);
                    ro_run <= (nxt_state == COUNT) ?
                              (pair_mask & en_q) : '0;
                    a_s1   <= ro_cnt[ia];
                    b_s1   <= ro_cnt[ib];
                    cnt_a  <= a_s1;
                    cnt_b  <= b_s1;
                end
            end

            for (genvar i = 0; i < N_RO; i++) begin : g_ro
                (* keep = "true", dont_touch = "true" *)
                logic [STAGES-1:0] chain;
                logic [CNT_W-1:0]  cnt;

                assign chain[0] = ~(ro_run[i] & chain[STAGES-1]);
                for (genvar j = 1; j < STAGES; j++) begin : g_inv
                    assign chain[j] = ~chain[j-1];
                end

                always_ff @(posedge chain[STAGES-1] or posedge ro_clr) begin
                    if (ro_clr)
                        cnt <= '0;
                    else if (cnt != '1)
                        cnt <= cnt + 1'b1;
                end

                assign ro_cnt[i] = cnt;
            end
        end
    endgenerate

endmodule

// File: tb/tb_puf_serial_engine.sv
// Bench for puf_serial_engine with the behavioural RO model and a short window.
// A sweep-level reference model is compared against the DUT every cycle.
module tb_puf_serial_engine;

    localparam int WIN = 8;
    localparam int L   = 2 + 8 * (WIN + 2);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] enables;
    logic [7:0]  challenge;
    logic [7:0]  response;
    logic        done;

    int checks   = 0;
    int failures = 0;

    puf_serial_engine #(
        .N_RO(32),
        .RESP_BITS(8),
        .WINDOW(WIN),
        .CNT_W(16),
        .STAGES(5),
        .SIM_RO(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enables(enables),
        .challenge(challenge),
        .response(response),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic int ro_rate(int i);
        return ((7 * i) % 16) + 1;
    endfunction

    function automatic logic [7:0] model_resp(
        input logic [7:0]  ch,
        input logic [31:0] en
    );
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            int a;
            int ca;
            int cb;
            a  = 4 * b + (ch[b] ? 2 : 0);
            ca = en[a]     ? WIN * ro_rate(a)     : 0;
            cb = en[a + 1] ? WIN * ro_rate(a + 1) : 0;
            r[b] = (ca > cb);
        end
        return r;
    endfunction

    // sweep-level model: inputs sampled at sweep start, result at sweep end
    int         cyc     = 0;
    bit         chk_en  = 0;
    logic [7:0] lat_ch;
    logic [31:0] lat_en;
    logic [7:0] exp_resp;
    logic       exp_done;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            cyc      = 0;
            exp_resp = '0;
            exp_done = 1'b0;
            chk_en   = 1;
        end else if (chk_en) begin
            cyc++;
            if ((cyc - 1) % L == 0) begin
                lat_ch = challenge;
                lat_en = enables;
            end
            if (cyc % L == 0) begin
                exp_resp = model_resp(lat_ch, lat_en);
                exp_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (response !== exp_resp || done !== exp_done) begin
                failures++;
                $display("FAIL cycle_cmp cyc=%0d got resp=%h done=%b want resp=%h done=%b",
                         cyc, response, done, exp_resp, exp_done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    // called on a negedge right after an update (or reset release)
    task automatic sweep(input string name, input logic [7:0] ch,
                         input logic [31:0] en, input bit do_mid,
                         input logic [7:0] mid_ch, input logic [31:0] mid_en,
                         input logic [7:0] want);
        challenge = ch;
        enables   = en;
        if (do_mid) begin
            repeat (40) @(posedge clk);
            @(negedge clk);
            challenge = mid_ch;
            enables   = mid_en;
            repeat (L - 41) @(posedge clk);
        end else begin
            repeat (L - 1) @(posedge clk);
        end
        @(negedge clk);
        check({name, "_pre_resp"}, {24'd0, response}, {24'd0, exp_resp});
        @(posedge clk);
        @(negedge clk);
        check({name, "_resp"}, {24'd0, response}, {24'd0, want});
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        challenge = 8'h63;
        enables   = '1;

        check("pin_63_all", {24'd0, model_resp(8'h63, '1)}, 32'h23);
        check("pin_00_all", {24'd0, model_resp(8'h00, '1)}, 32'h22);
        check("pin_ro2_off", {24'd0, model_resp(8'h63, 32'hFFFF_FFFB)}, 32'h22);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp", {24'd0, response}, 32'h0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        repeat (L - 1) @(posedge clk);
        @(negedge clk);
        check("first_pre_done", {31'd0, done}, 32'd0);
        check("first_pre_resp", {24'd0, response}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("first_done", {31'd0, done}, 32'd1);
        check("first_resp", {24'd0, response}, 32'h23);

        sweep("ch00", 8'h00, '1, 0, 8'h00, '1, 8'h22);
        sweep("en_none", 8'h63, 32'h0, 0, 8'h00, '0, 8'h00);
        sweep("ro0_off", 8'h63, 32'hFFFF_FFFE, 0, 8'h00, '0, 8'h23);
        sweep("ro2_off", 8'h63, 32'hFFFF_FFFB, 0, 8'h00, '0, 8'h22);
        sweep("mid_chg", 8'h63, '1, 1, 8'h00, '1, 8'h23);
        sweep("after_chg", 8'h00, '1, 0, 8'h00, '1, 8'h22);

        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_resp", {24'd0, response}, 32'h0);
        check("midrst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        sweep("post_rst", 8'h63, '1, 0, 8'h00, '0, 8'h23);

        for (int r = 0; r < 6; r++) begin
            logic [7:0]  ch;
            logic [31:0] en;
            logic [7:0]  mch;
            logic [31:0] men;
            ch  = 8'($urandom);
            en  = $urandom;
            mch = 8'($urandom);
            men = $urandom;
            sweep($sformatf("rand%0d", r), ch, en, r[0], mch, men,
                  model_resp(ch, en));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
